// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } ld_state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  function automatic logic in_rx_state(ld_state_t s);
    return (s == LEN0) || (s == LEN1) || (s == DATA);
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian word assembler: inserts stream bytes at the current byte slot.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0]  idx_r;
  logic [31:0] word_r;

  // Byte slot pointer and word register; clear wins over load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (clr) begin
      idx_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (load) begin
      word_r[{idx_r, 3'b000} +: 8] <= byte_in;
      idx_r                        <= idx_r + 2'd1;
    end else begin
      idx_r  <= idx_r;
      word_r <= word_r;
    end
  end

  // full means the next load completes the word.
  assign full = (idx_r == 2'(WORD_BYTES - 1));
  assign word = word_r;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory; holds the CPU while loading.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              imem_wren,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int              TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LIM = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : {TO_W{1'b0}};
  localparam logic [16:0]     DEPTH  = 17'd1 << ADDR_W;

  ld_state_t         state_r;
  ld_state_t         nxt_s;
  logic [7:0]        n_lo_r;
  logic [15:0]       n_r;
  logic [ADDR_W-1:0] idx_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              xfer_s;
  logic              to_hit_s;
  logic              start_s;
  logic              last_s;
  logic [16:0]       n_new_s;
  logic [31:0]       asm_word_s;
  logic              asm_full_s;

  assign xfer_s   = rx_valid & rx_ready;
  assign start_s  = load_start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));
  assign n_new_s  = {1'b0, rx_data, n_lo_r};
  assign last_s   = ({{(17-ADDR_W){1'b0}}, idx_r} == ({1'b0, n_r} - 17'd1));
  assign to_hit_s = (TIMEOUT_CYC != 0) && in_rx_state(state_r) && !xfer_s && (to_cnt_r == TO_LIM);

  // A timed-out partial word is dropped by clearing the assembler.
  loader_word_asm u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_s | to_hit_s),
    .load    (xfer_s & (state_r == DATA)),
    .byte_in (rx_data),
    .word    (asm_word_s),
    .full    (asm_full_s)
  );

  // Next-state decode.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (load_start) nxt_s = LEN0;
        else            nxt_s = state_r;
      end
      LEN0: begin
        if (xfer_s)        nxt_s = LEN1;
        else if (to_hit_s) nxt_s = ERR;
        else               nxt_s = LEN0;
      end
      LEN1: begin
        if (xfer_s) begin
          if (n_new_s == 17'd0)     nxt_s = DONE;
          else if (n_new_s > DEPTH) nxt_s = ERR;
          else                      nxt_s = DATA;
        end else if (to_hit_s) begin
          nxt_s = ERR;
        end else begin
          nxt_s = LEN1;
        end
      end
      DATA: begin
        if (xfer_s && asm_full_s) nxt_s = WRITE;
        else if (to_hit_s)        nxt_s = ERR;
        else                      nxt_s = DATA;
      end
      WRITE: begin
        if (last_s) nxt_s = DONE;
        else        nxt_s = DATA;
      end
      default: nxt_s = IDLE;
    endcase
  end

  // State register with outputs decoded from the incoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      rx_ready  <= 1'b0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      imem_wren <= 1'b0;
    end else begin
      state_r   <= nxt_s;
      rx_ready  <= in_rx_state(nxt_s);
      cpu_hold  <= in_rx_state(nxt_s) | (nxt_s == WRITE) | (nxt_s == ERR);
      load_done <= (nxt_s == DONE);
      load_err  <= (nxt_s == ERR);
      imem_wren <= (nxt_s == WRITE);
    end
  end

  // Word count, word index and inter-byte idle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_lo_r   <= 8'd0;
      n_r      <= 16'd0;
      idx_r    <= {ADDR_W{1'b0}};
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      if (state_r == LEN0 && xfer_s) n_lo_r <= rx_data;
      else                           n_lo_r <= n_lo_r;

      if (state_r == LEN1 && xfer_s) n_r <= n_new_s[15:0];
      else                           n_r <= n_r;

      if (start_s)                          idx_r <= {ADDR_W{1'b0}};
      else if (state_r == WRITE && !last_s) idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      else                                  idx_r <= idx_r;

      if (in_rx_state(state_r) && !xfer_s && !to_hit_s) to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      else                                              to_cnt_r <= {TO_W{1'b0}};
    end
  end

  assign imem_addr = idx_r;
  assign imem_data = asm_word_s;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (ADDR_W=4, TIMEOUT_CYC=50).
module tb_imem_loader;

  localparam int AW = 4;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_wren;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  int n_pass = 0;
  int n_total = 0;
  int wr_cnt = 0;
  int wr_mark;
  logic [AW+31:0] exp_q[$];

  imem_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_wren(imem_wren), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst && imem_wren) begin
      wr_cnt++;
      chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_write: addr %0d data %h, expected no write", imem_addr, imem_data);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {28'd0, imem_addr}, {28'd0, e[AW+31:32]});
        chk("wr_data", imem_data, e[31:0]);
      end
    end
  end

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // duty = percent chance rx_valid is offered in a given cycle (100 = back to back).
  task automatic send_byte(input logic [7:0] b, input int duty);
    int waited;
    int gaps;
    gaps = 0;
    while (duty < 100 && $urandom_range(99) >= duty && gaps < 20) begin
      rx_valid = 1'b0;
      @(negedge clk);
      gaps++;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      n_total++;
      $display("FAIL rx_ready_wait: rx_ready stayed 0, expected 1 within 100 cycles");
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input int duty);
    exp_q.push_back({a, w});
    send_byte(w[7:0], duty);
    send_byte(w[15:8], duty);
    send_byte(w[23:16], duty);
    send_byte(w[31:24], duty);
  endtask

  task automatic run_t1(input int duty, input string tag);
    logic [7:0] s [14] = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                           8'h77, 8'h88, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wr_mark = wr_cnt;
    start_load();
    chk({tag, "_done_cleared"}, {31'd0, load_done}, 32'd0);
    exp_q.push_back({4'd0, 32'h44332211});
    exp_q.push_back({4'd1, 32'h88776655});
    exp_q.push_back({4'd2, 32'hDDCCBBAA});
    for (int i = 0; i < 14; i++) send_byte(s[i], duty);
    chk({tag, "_wren_after_last"}, {31'd0, imem_wren}, 32'd1);
    chk({tag, "_hold_at_last_wr"}, {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    chk({tag, "_hold_released"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_load_done"}, {31'd0, load_done}, 32'd1);
    chk({tag, "_wr_count"}, wr_cnt - wr_mark, 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_wren", {31'd0, imem_wren}, 32'd0);
    chk("rst_addr_data", imem_data | {28'd0, imem_addr}, 32'd0);
    chk("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // T1: N=3 back to back; rx_valid is re-raised during each WRITE bubble
    run_t1(100, "t1");

    // T2: N=0
    wr_mark = wr_cnt;
    start_load();
    send_byte(8'h00, 100);
    send_byte(8'h00, 100);
    chk("t2_done", {31'd0, load_done}, 32'd1);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t2_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("t2_no_write", wr_cnt - wr_mark, 32'd0);

    // T3: N=17 exceeds depth 16, then a full-depth load
    wr_mark = wr_cnt;
    start_load();
    send_byte(8'h11, 100);
    send_byte(8'h00, 100);
    chk("t3_err", {31'd0, load_err}, 32'd1);
    chk("t3_err_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t3_err_not_done", {31'd0, load_done}, 32'd0);
    chk("t3_no_write", wr_cnt - wr_mark, 32'd0);
    start_load();
    chk("t3_err_cleared", {31'd0, load_err}, 32'd0);
    send_byte(8'h10, 100);
    send_byte(8'h00, 100);
    for (int i = 0; i < 16; i++) send_word(AW'(i), 32'hC0DE_0000 | (32'(i) * 32'h0101), 100);
    @(negedge clk);
    chk("t3_done", {31'd0, load_done}, 32'd1);
    chk("t3_last_addr", {28'd0, imem_addr}, 32'd15);
    chk("t3_wr_count", wr_cnt - wr_mark, 32'd16);

    // T4: same stream as T1 with sparse rx_valid
    run_t1(30, "t4");

    // T5: timeout after 2 bytes of word 1
    wr_mark = wr_cnt;
    start_load();
    send_byte(8'h02, 100);
    send_byte(8'h00, 100);
    send_word(4'd0, 32'h04030201, 100);
    send_byte(8'h05, 100);
    send_byte(8'h06, 100);
    repeat (TO - 1) @(negedge clk);
    chk("t5_no_err_early", {31'd0, load_err}, 32'd0);
    @(negedge clk);
    chk("t5_err_at_limit", {31'd0, load_err}, 32'd1);
    chk("t5_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t5_only_word0", wr_cnt - wr_mark, 32'd1);

    // T6: asynchronous reset mid-DATA, then a clean load
    start_load();
    send_byte(8'h02, 100);
    send_byte(8'h00, 100);
    send_byte(8'h01, 100);
    send_byte(8'h02, 100);
    send_byte(8'h03, 100);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t6_rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("t6_rst_addr_data", imem_data | {28'd0, imem_addr}, 32'd0);
    chk("t6_rst_flags", {30'd0, load_done, load_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr_mark = wr_cnt;
    start_load();
    send_byte(8'h01, 100);
    send_byte(8'h00, 100);
    exp_q.push_back({4'd0, 32'hEFBEADDE});
    send_byte(8'hDE, 100);
    send_byte(8'hAD, 100);
    send_byte(8'hBE, 100);
    send_byte(8'hEF, 100);
    @(negedge clk);
    chk("t6_done", {31'd0, load_done}, 32'd1);
    chk("t6_wr_count", wr_cnt - wr_mark, 32'd1);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
